// File: rtl/flash_loader_pkg.sv
// Shared encodings for the SPI-flash-to-RAM boot loader.
package flash_loader_pkg;

    // RAMIO write_type encodings
    localparam logic [1:0] WT_NONE = 2'b00;
    localparam logic [1:0] WT_BYTE = 2'b01;
    localparam logic [1:0] WT_HALF = 2'b10;
    localparam logic [1:0] WT_WORD = 2'b11;

    // SPI flash "read data" command
    localparam logic [7:0] FLASH_CMD_READ = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND,
        ST_RECV,
        ST_WRITE,
        ST_WAIT_RAM,
        ST_DONE
    } state_t;

    // Flash bytes arrive first-byte-in-MSB; RAM words are little-endian.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/flash_loader.sv
// Copies BYTE_COUNT bytes from SPI flash (mode 0, one read command) into RAM
// as 32-bit little-endian words through the RAMIO command port.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | after reset, waiting for start
// ST_WAIT     | flash power-up wait, cs high, STARTUP_WAIT cycles
// ST_SEND     | shifting out 8'h03 + 24-bit address, 2 cycles per bit
// ST_RECV     | shifting in one 32-bit word, 2 cycles per bit
// ST_WRITE    | issuing the RAM word write (held while ramio_busy)
// ST_WAIT_RAM | waiting for RAMIO to go idle, then next word or finish
// ST_DONE     | load complete, done sticky until a new start
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter logic [23:0] FLASH_ADDRESS = 24'h00_0000,
    parameter logic [31:0] RAM_BASE      = 32'h0000_0000,
    parameter int          BYTE_COUNT    = 4096,
    parameter int          STARTUP_WAIT  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        flash_cs,
    output logic        ramio_enable,
    output logic [1:0]  ramio_write_type,
    output logic [2:0]  ramio_read_type,
    output logic [31:0] ramio_address,
    output logic [31:0] ramio_data_in,
    input  logic        ramio_busy
);

    localparam int NUM_WORDS = BYTE_COUNT / 4;
    localparam int WIDX_W    = $clog2(NUM_WORDS + 1);
    localparam int WAIT_W    = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT) : 1;

    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_WORDS);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(STARTUP_WAIT - 1);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [5:0]          phase_q, phase_d;    // [5:1] bit number, [0] = phase B
    logic [31:0]         shift_q, shift_d;
    logic [WIDX_W-1:0]   word_q, word_d;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                en_q, en_d;
    logic [1:0]          wt_q, wt_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [31:0]         rx_word;
    logic [31:0]         word_addr;

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        word_d    = word_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        en_d      = 1'b0;
        wt_d      = wt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        rx_word   = {shift_q[30:0], flash_miso};
        word_addr = RAM_BASE + (32'(word_q) << 2);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    wait_d  = WAIT_LOAD;
                    word_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    cs_d    = 1'b1;
                    sclk_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_SEND;
                    phase_d = '0;
                    shift_d = {FLASH_CMD_READ, FLASH_ADDRESS};
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = FLASH_CMD_READ[7];
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_SEND: begin
                phase_d = phase_q + 1'b1;
                if (!phase_q[0]) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    if (phase_q == 6'd63) begin
                        state_d = ST_RECV;
                        mosi_d  = 1'b0;
                    end else begin
                        shift_d = {shift_q[30:0], 1'b0};
                        mosi_d  = shift_q[30];
                    end
                end
            end
            ST_RECV: begin
                phase_d = phase_q + 1'b1;
                if (!phase_q[0]) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d  = 1'b0;
                    shift_d = rx_word;
                    if (phase_q == 6'd63) begin
                        state_d = ST_WRITE;
                        if (!ramio_busy) begin
                            en_d   = 1'b1;
                            wt_d   = WT_WORD;
                            addr_d = word_addr;
                            data_d = byte_swap(rx_word);
                        end
                    end
                end
            end
            ST_WRITE: begin
                // en_q high means the command is on the bus this cycle.
                if (en_q) begin
                    state_d = ST_WAIT_RAM;
                    word_d  = word_q + 1'b1;
                end else if (!ramio_busy) begin
                    en_d   = 1'b1;
                    wt_d   = WT_WORD;
                    addr_d = word_addr;
                    data_d = byte_swap(shift_q);
                end
            end
            ST_WAIT_RAM: begin
                if (!ramio_busy) begin
                    if (word_q == LAST_WORD) begin
                        state_d = ST_DONE;
                        cs_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RECV;
                        phase_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            phase_q <= '0;
            shift_q <= '0;
            word_q  <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            en_q    <= 1'b0;
            wt_q    <= WT_NONE;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            phase_q <= phase_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            en_q    <= en_d;
            wt_q    <= wt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign flash_cs         = cs_q;
    assign flash_clk        = sclk_q;
    assign flash_mosi       = mosi_q;
    assign ramio_enable     = en_q;
    assign ramio_write_type = wt_q;
    assign ramio_read_type  = 3'b000;
    assign ramio_address    = addr_q;
    assign ramio_data_in    = data_q;

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader with a behavioural SPI flash model.
module tb_flash_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ramio_busy = 1'b0;
    logic        flash_miso = 1'b0;

    logic        busy, done, flash_clk, flash_mosi, flash_cs, ramio_enable;
    logic [1:0]  ramio_write_type;
    logic [2:0]  ramio_read_type;
    logic [31:0] ramio_address, ramio_data_in;

    logic        b_busy, b_done, b_flash_clk, b_flash_mosi, b_flash_cs, b_en;
    logic [1:0]  b_wt;
    logic [2:0]  b_rt;
    logic [31:0] b_addr, b_data;

    flash_loader #(
        .FLASH_ADDRESS (24'h00_0000),
        .RAM_BASE      (32'h0000_0000),
        .BYTE_COUNT    (8),
        .STARTUP_WAIT  (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .flash_clk        (flash_clk),
        .flash_mosi       (flash_mosi),
        .flash_miso       (flash_miso),
        .flash_cs         (flash_cs),
        .ramio_enable     (ramio_enable),
        .ramio_write_type (ramio_write_type),
        .ramio_read_type  (ramio_read_type),
        .ramio_address    (ramio_address),
        .ramio_data_in    (ramio_data_in),
        .ramio_busy       (ramio_busy)
    );

    // Second instance exercises RAM address wrap; it shares the flash data.
    flash_loader #(
        .FLASH_ADDRESS (24'h00_0000),
        .RAM_BASE      (32'hFFFF_FFFC),
        .BYTE_COUNT    (8),
        .STARTUP_WAIT  (4)
    ) dut_wrap (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (b_busy),
        .done             (b_done),
        .flash_clk        (b_flash_clk),
        .flash_mosi       (b_flash_mosi),
        .flash_miso       (flash_miso),
        .flash_cs         (b_flash_cs),
        .ramio_enable     (b_en),
        .ramio_write_type (b_wt),
        .ramio_read_type  (b_rt),
        .ramio_address    (b_addr),
        .ramio_data_in    (b_data),
        .ramio_busy       (1'b0)
    );

    always #5 clk = ~clk;

    // SPI flash model: captures 32 command bits on rising sclk, then drives
    // data bytes MSB first on each falling sclk, auto-incrementing.
    logic [7:0]  fmem [0:7];
    logic [31:0] cmd_cap = '0;
    int          rise_cnt = 0;
    int          out_cnt = 0;

    initial begin
        fmem[0] = 8'h11; fmem[1] = 8'h22; fmem[2] = 8'h33; fmem[3] = 8'h44;
        fmem[4] = 8'h55; fmem[5] = 8'h66; fmem[6] = 8'h77; fmem[7] = 8'h88;
    end

    always @(posedge flash_clk or negedge flash_clk or posedge flash_cs) begin
        logic [7:0] cur;
        int idx;
        if (flash_cs) begin
            rise_cnt <= 0;
            out_cnt  <= 0;
        end else if (flash_clk) begin
            if (rise_cnt < 32) cmd_cap <= {cmd_cap[30:0], flash_mosi};
            rise_cnt <= rise_cnt + 1;
        end else if (rise_cnt >= 32) begin
            idx = (int'(cmd_cap[23:0]) + out_cnt / 8) & 7;
            cur = fmem[idx];
            flash_miso <= cur[7 - (out_cnt % 8)];
            out_cnt <= out_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    int          wr_cyc  [0:7];
    logic [31:0] wr_addr [0:7];
    logic [31:0] wr_data [0:7];
    logic [1:0]  wr_wt   [0:7];
    int          n_wr;
    logic [31:0] wb_addr [0:7];
    int          n_wr_b;
    int          first_cs, done_cyc, rt_bad;
    logic        busy_c1, done_c1, busy_at_done, cs_after_rst;

    // Pulses start at cycle 0 and steps cycles, observing #1 after each edge.
    task automatic run_load(input int busy_at, input int rst_at, input int extra_start,
                            input int max_cyc);
        int cyc;
        n_wr = 0; n_wr_b = 0; first_cs = -1; done_cyc = -1; rt_bad = 0;
        busy_c1 = 1'b0; done_c1 = 1'b1; busy_at_done = 1'b1; cs_after_rst = 1'b0;
        start = 1'b1;
        cyc = 0;
        while (cyc < max_cyc && done_cyc < 0) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == extra_start);
            ramio_busy = (busy_at >= 0 && cyc >= busy_at && cyc < busy_at + 10);
            if (cyc == 1) begin
                busy_c1 = busy;
                done_c1 = done;
            end
            if (rst_at >= 0 && cyc == rst_at) rst = 1'b1;
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                rst = 1'b0;
                cs_after_rst = flash_cs;
            end
            if (!flash_cs && first_cs < 0) first_cs = cyc;
            if (ramio_read_type != 3'b000) rt_bad++;
            if (ramio_enable) begin
                if (n_wr < 8) begin
                    wr_cyc[n_wr]  = cyc;
                    wr_addr[n_wr] = ramio_address;
                    wr_data[n_wr] = ramio_data_in;
                    wr_wt[n_wr]   = ramio_write_type;
                end
                n_wr++;
            end
            if (b_en) begin
                if (n_wr_b < 8) wb_addr[n_wr_b] = b_addr;
                n_wr_b++;
            end
            if (done) begin
                done_cyc = cyc;
                busy_at_done = busy;
            end
        end
        start = 1'b0;
        ramio_busy = 1'b0;
    endtask

    task automatic check_std_load(input string tag, input int shift);
        check({tag, " n_wr"},    n_wr, 2);
        check({tag, " cyc0"},    wr_cyc[0], 133 + shift);
        check({tag, " addr0"},   wr_addr[0], 32'h0000_0000);
        check({tag, " data0"},   wr_data[0], 32'h4433_2211);
        check({tag, " wt0"},     {30'd0, wr_wt[0]}, 32'd3);
        check({tag, " cyc1"},    wr_cyc[1], 199 + shift);
        check({tag, " addr1"},   wr_addr[1], 32'h0000_0004);
        check({tag, " data1"},   wr_data[1], 32'h8877_6655);
        check({tag, " done"},    done_cyc, 201 + shift);
        check({tag, " busy_c1"}, {31'd0, busy_c1}, 32'd1);
        check({tag, " busy@dn"}, {31'd0, busy_at_done}, 32'd0);
        check({tag, " rtype"},   rt_bad, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst cs",    {31'd0, flash_cs}, 32'd1);
        check("rst sclk",  {31'd0, flash_clk}, 32'd0);
        check("rst mosi",  {31'd0, flash_mosi}, 32'd0);
        check("rst en",    {31'd0, ramio_enable}, 32'd0);
        check("rst wt",    {30'd0, ramio_write_type}, 32'd0);
        check("rst addr",  ramio_address, 32'd0);
        check("rst data",  ramio_data_in, 32'd0);
        check("rst busy",  {31'd0, busy}, 32'd0);
        check("rst done",  {31'd0, done}, 32'd0);

        // Basic load
        run_load(-1, -1, -1, 400);
        check_std_load("basic", 0);
        check("cs fall", first_cs, 5);
        check("mosi cmd", cmd_cap, 32'h0300_0000);
        check("wrap n", n_wr_b, 2);
        check("wrap addr0", wb_addr[0], 32'hFFFF_FFFC);
        check("wrap addr1", wb_addr[1], 32'h0000_0000);

        // Restart from DONE with a stray start mid-load that must be ignored
        run_load(-1, -1, 50, 400);
        check("redo done_c1", {31'd0, done_c1}, 32'd0);
        check_std_load("redo", 0);

        // RAMIO busy for 10 cycles at the first write
        run_load(132, -1, -1, 400);
        check("stall n_wr",  n_wr, 2);
        check("stall cyc0",  wr_cyc[0], 143);
        check("stall data0", wr_data[0], 32'h4433_2211);
        check("stall addr0", wr_addr[0], 32'h0000_0000);
        check("stall cyc1",  wr_cyc[1], 209);
        check("stall data1", wr_data[1], 32'h8877_6655);
        check("stall done",  done_cyc, 211);

        // Reset during RECV of word 1
        run_load(-1, 150, -1, 260);
        check("abort cs",   {31'd0, cs_after_rst}, 32'd1);
        check("abort n_wr", n_wr, 1);
        check("abort done", done_cyc, -1);
        check("abort dlvl", {31'd0, done}, 32'd0);

        // Fresh load after the abort reproduces the basic run
        run_load(-1, -1, -1, 400);
        check_std_load("after", 0);
        check("after cs fall", first_cs, 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
